// File: rtl/cavlc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cavlc_pkg                                                                  |
// | Shared states, escape constants and widths for the CAVLC level path.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package cavlc_pkg;

  typedef logic [2:0] state_t;

  localparam state_t C_ST_IDLE   = 3'd0;
  localparam state_t C_ST_T1SIGN = 3'd1;
  localparam state_t C_ST_PREFIX = 3'd2;
  localparam state_t C_ST_SUFFIX = 3'd3;
  localparam state_t C_ST_FINISH = 3'd4;

  localparam int C_MAX_SUFFIX_LEN = 6;

  // Escape codes: prefix 14 with suffixLength 0 reads 4 bits, prefix 15 reads 12
  localparam logic [3:0]  C_ESC14_PREFIX = 4'd14;
  localparam logic [3:0]  C_ESC14_SIZE   = 4'd4;
  localparam logic [3:0]  C_ESC15_PREFIX = 4'd15;
  localparam logic [3:0]  C_ESC15_SIZE   = 4'd12;
  localparam logic [13:0] C_ESC15_OFFSET = 14'd15;

  localparam int C_CODENUM_W  = 14;
  localparam int C_LEVELOUT_W = 13;

endpackage
`default_nettype wire

// File: rtl/leading_zero_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | leading_zero_counter                                                       |
// | Counts leading zeros of a 16-bit word; returns 16 for an all-zero word.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module leading_zero_counter (
  input  logic [15:0] value,
  output logic [4:0]  count
);

  // Ascending scan: the highest set bit is the last one to write the result
  always_comb begin
    count = 5'd16;
    for (int k = 0; k < 16; k++) begin
      if (value[k]) count = 5'(15 - k);
    end
  end

endmodule
`default_nettype wire

// File: rtl/level_code_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | level_code_decoder                                                         |
// | Parses trailing-one signs and level prefix/suffix, tracks suffixLength.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module level_code_decoder
  import cavlc_pkg::*;
#(
  parameter int MAX_SUFFIX_LEN = C_MAX_SUFFIX_LEN
) (
  input  logic                   Clk,
  input  logic                   nReset,
  input  logic                   Start,
  input  logic [4:0]             TotalCoeffIn,
  input  logic [1:0]             TrailingOnesIn,
  input  logic [15:0]            BitsIn,
  input  logic                   BitsValid,
  output logic                   ShiftEn,
  output logic [4:0]             ShiftAmt,
  output logic                   TrailingOneMode,
  output logic                   LPUTrig,
  output logic [C_CODENUM_W-1:0] CodeNum,
  output logic [2:0]             SuffixLength,
  output logic [1:0]             TrailingOnes,
  output logic                   Busy,
  output logic                   Done,
  output logic                   Error
);

  localparam logic [2:0] C_SL_MAX = 3'(MAX_SUFFIX_LEN);

  state_t                 r_state;
  logic [4:0]             r_tc;
  logic [1:0]             r_t1;
  logic [4:0]             r_idx;
  logic [2:0]             r_sl;
  logic [3:0]             r_prefix;
  logic                   r_first;
  logic [C_CODENUM_W-1:0] r_codenum;
  logic [2:0]             r_suffixlen;
  logic                   r_t1mode;
  logic                   r_lputrig;
  logic                   r_done;
  logic                   r_error;

  logic [4:0]             w_lz;
  logic [3:0]             w_ssize;
  logic [11:0]            w_suffix;
  logic [C_CODENUM_W-1:0] w_levelcode;
  logic [C_CODENUM_W-1:0] w_adj;
  logic [C_CODENUM_W-1:0] w_mag;
  logic [C_CODENUM_W-1:0] w_thresh;
  logic [2:0]             w_sl_base;
  logic [2:0]             w_sl_next;
  logic [4:0]             w_idx_next;
  logic                   w_suffix_go;

  leading_zero_counter u_lzc (
    .value (BitsIn),
    .count (w_lz)
  );

  always_comb begin
    if (r_prefix == C_ESC15_PREFIX) begin
      w_ssize = C_ESC15_SIZE;
    end else if (r_prefix == C_ESC14_PREFIX && r_sl == 3'd0) begin
      w_ssize = C_ESC14_SIZE;
    end else begin
      w_ssize = {1'b0, r_sl};
    end
  end

  // A zero-size suffix shifts the window out entirely, yielding 0
  assign w_suffix    = 12'(BitsIn >> (5'd16 - {1'b0, w_ssize}));
  assign w_levelcode = (14'(r_prefix) << r_sl) + 14'(w_suffix)
                     + ((r_prefix == C_ESC15_PREFIX && r_sl == 3'd0) ? C_ESC15_OFFSET : 14'd0);

  // The +2 for the first non-T1 level only steers suffixLength adaptation here
  assign w_adj       = (r_first && r_t1 != 2'd3) ? w_levelcode + 14'd2 : w_levelcode;
  assign w_mag       = (w_adj + 14'd2) >> 1;
  assign w_sl_base   = (r_sl == 3'd0) ? 3'd1 : r_sl;
  assign w_thresh    = 14'd3 << (w_sl_base - 3'd1);
  assign w_sl_next   = (w_mag > w_thresh && w_sl_base < C_SL_MAX) ? w_sl_base + 3'd1 : w_sl_base;
  assign w_idx_next  = r_idx + 5'd1;
  assign w_suffix_go = (r_state == C_ST_SUFFIX) && (w_ssize == 4'd0 || BitsValid);

  always_comb begin
    ShiftEn  = 1'b0;
    ShiftAmt = 5'd0;
    case (r_state)
      C_ST_T1SIGN: begin
        if (BitsValid) begin
          ShiftEn  = 1'b1;
          ShiftAmt = 5'd1;
        end
      end
      C_ST_PREFIX: begin
        if (BitsValid && !w_lz[4]) begin
          ShiftEn  = 1'b1;
          ShiftAmt = w_lz + 5'd1;
        end
      end
      C_ST_SUFFIX: begin
        if (BitsValid && w_ssize != 4'd0) begin
          ShiftEn  = 1'b1;
          ShiftAmt = {1'b0, w_ssize};
        end
      end
      default: begin
        ShiftEn  = 1'b0;
        ShiftAmt = 5'd0;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      r_state     <= C_ST_IDLE;
      r_tc        <= 5'd0;
      r_t1        <= 2'd0;
      r_idx       <= 5'd0;
      r_sl        <= 3'd0;
      r_prefix    <= 4'd0;
      r_first     <= 1'b0;
      r_codenum   <= '0;
      r_suffixlen <= 3'd0;
      r_t1mode    <= 1'b0;
      r_lputrig   <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_t1mode  <= 1'b0;
      r_lputrig <= 1'b0;
      r_done    <= 1'b0;
      case (r_state)
        C_ST_IDLE: begin
          if (Start) begin
            r_tc    <= TotalCoeffIn;
            r_t1    <= TrailingOnesIn;
            r_idx   <= 5'd0;
            r_first <= 1'b1;
            r_error <= 1'b0;
            r_sl    <= (TotalCoeffIn > 5'd10 && TrailingOnesIn != 2'd3) ? 3'd1 : 3'd0;
            if (TrailingOnesIn != 2'd0) begin
              r_state <= C_ST_T1SIGN;
            end else if (TotalCoeffIn != 5'd0) begin
              r_state <= C_ST_PREFIX;
            end else begin
              r_state <= C_ST_FINISH;
            end
          end
        end
        C_ST_T1SIGN: begin
          if (BitsValid) begin
            r_codenum <= {13'd0, BitsIn[15]};
            r_t1mode  <= 1'b1;
            r_idx     <= w_idx_next;
            if (w_idx_next == {3'd0, r_t1}) begin
              r_state <= (r_tc > {3'd0, r_t1}) ? C_ST_PREFIX : C_ST_FINISH;
            end
          end
        end
        C_ST_PREFIX: begin
          if (BitsValid) begin
            if (w_lz[4]) begin
              r_error <= 1'b1;
              r_state <= C_ST_FINISH;
            end else begin
              r_prefix <= w_lz[3:0];
              r_state  <= C_ST_SUFFIX;
            end
          end
        end
        C_ST_SUFFIX: begin
          if (w_suffix_go) begin
            r_codenum   <= w_levelcode;
            r_suffixlen <= r_sl;
            r_lputrig   <= 1'b1;
            r_idx       <= w_idx_next;
            r_sl        <= w_sl_next;
            r_first     <= 1'b0;
            r_state     <= (w_idx_next < r_tc) ? C_ST_PREFIX : C_ST_FINISH;
          end
        end
        C_ST_FINISH: begin
          r_done  <= 1'b1;
          r_state <= C_ST_IDLE;
        end
        default: r_state <= C_ST_IDLE;
      endcase
    end
  end

  assign CodeNum         = r_codenum;
  assign SuffixLength    = r_suffixlen;
  assign TrailingOneMode = r_t1mode;
  assign LPUTrig         = r_lputrig;
  assign TrailingOnes    = r_t1;
  assign Busy            = (r_state != C_ST_IDLE);
  assign Done            = r_done;
  assign Error           = r_error;

endmodule
`default_nettype wire

// File: tb/tb_level_code_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_level_code_decoder                                                      |
// | Directed and random blocks against a bit-queue reference decoder.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_level_code_decoder;

  logic        Clk = 1'b0;
  logic        nReset;
  logic        Start;
  logic [4:0]  TotalCoeffIn;
  logic [1:0]  TrailingOnesIn;
  logic [15:0] BitsIn;
  logic        BitsValid;
  logic        ShiftEn;
  logic [4:0]  ShiftAmt;
  logic        TrailingOneMode;
  logic        LPUTrig;
  logic [13:0] CodeNum;
  logic [2:0]  SuffixLength;
  logic [1:0]  TrailingOnes;
  logic        Busy;
  logic        Done;
  logic        Error;

  int total = 0;
  int bad   = 0;

  bit stream[$];
  int rd;
  int exp_kind[$], exp_code[$], exp_sl[$];
  int got_kind[$], got_code[$], got_sl[$];
  int exp_err, exp_pos;

  always #5 Clk = ~Clk;

  level_code_decoder dut (
    .Clk             (Clk),
    .nReset          (nReset),
    .Start           (Start),
    .TotalCoeffIn    (TotalCoeffIn),
    .TrailingOnesIn  (TrailingOnesIn),
    .BitsIn          (BitsIn),
    .BitsValid       (BitsValid),
    .ShiftEn         (ShiftEn),
    .ShiftAmt        (ShiftAmt),
    .TrailingOneMode (TrailingOneMode),
    .LPUTrig         (LPUTrig),
    .CodeNum         (CodeNum),
    .SuffixLength    (SuffixLength),
    .TrailingOnes    (TrailingOnes),
    .Busy            (Busy),
    .Done            (Done),
    .Error           (Error)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int bit_at(input int i);
    return (i < stream.size()) ? int'(stream[i]) : 0;
  endfunction

  function automatic logic [15:0] window();
    logic [15:0] w;
    for (int k = 0; k < 16; k++) w[15-k] = (bit_at(rd + k) != 0);
    return w;
  endfunction

  task automatic push_bits(input logic [31:0] v, input int n);
    for (int k = n - 1; k >= 0; k--) stream.push_back(v[k]);
  endtask

  task automatic push_ones(input int n);
    for (int k = 0; k < n; k++) stream.push_back(1'b1);
  endtask

  // Reference: read the stream bit by bit and apply the level decoding rules
  task automatic model(input int tc, input int t1);
    int pos, sl, p, sz, suf, lc, adj, mag;
    exp_kind.delete(); exp_code.delete(); exp_sl.delete();
    exp_err = 0;
    pos = 0;
    sl = (tc > 10 && t1 < 3) ? 1 : 0;
    for (int i = 0; i < t1; i++) begin
      exp_kind.push_back(1); exp_code.push_back(bit_at(pos)); exp_sl.push_back(0);
      pos++;
    end
    for (int k = t1; k < tc; k++) begin
      p = 0;
      while (p < 16 && bit_at(pos + p) == 0) p++;
      if (p == 16) begin
        exp_err = 1;
        break;
      end
      pos += p + 1;
      if (p == 15) sz = 12;
      else if (p == 14 && sl == 0) sz = 4;
      else sz = sl;
      suf = 0;
      for (int b = 0; b < sz; b++) begin
        suf = suf * 2 + bit_at(pos);
        pos++;
      end
      lc = p * (1 << sl) + suf;
      if (p == 15 && sl == 0) lc += 15;
      exp_kind.push_back(2); exp_code.push_back(lc); exp_sl.push_back(sl);
      adj = lc + ((k == t1 && t1 < 3) ? 2 : 0);
      mag = (adj + 2) / 2;
      if (sl == 0) sl = 1;
      if (mag > 3 * (1 << (sl - 1)) && sl < 6) sl++;
    end
    exp_pos = pos;
  endtask

  task automatic run_block(input int tc, input int t1, input bit stall, input bit extra);
    bit   done_seen;
    bit   sh_en;
    int   sh_amt;
    int   done_cyc;
    logic err_d;
    logic busy_d;
    logic [1:0] t1_d;
    int   n;
    model(tc, t1);
    got_kind.delete(); got_code.delete(); got_sl.delete();
    rd = 0; done_seen = 0; done_cyc = 0; err_d = 0; busy_d = 0; t1_d = 0;
    @(posedge Clk); #1;
    TotalCoeffIn = 5'(tc); TrailingOnesIn = 2'(t1); Start = 1'b1;
    BitsIn = window(); BitsValid = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
    for (int j = 0; j < 3000 && !done_seen; j++) begin
      @(negedge Clk);
      if (TrailingOneMode) begin
        got_kind.push_back(1); got_code.push_back(int'(CodeNum)); got_sl.push_back(int'(SuffixLength));
      end
      if (LPUTrig) begin
        got_kind.push_back(2); got_code.push_back(int'(CodeNum)); got_sl.push_back(int'(SuffixLength));
      end
      if (j == 1) check("busy_after_start", Busy, 1);
      sh_en = ShiftEn; sh_amt = int'(ShiftAmt);
      if (Done) begin
        done_seen = 1; done_cyc = j; err_d = Error; busy_d = Busy; t1_d = TrailingOnes;
      end
      @(posedge Clk); #1;
      Start = (extra && j == 0 && tc >= 2);
      if (Start) TotalCoeffIn = 5'($urandom_range(0, 16));
      if (sh_en) rd += sh_amt;
      BitsIn = window();
      BitsValid = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
    Start = 1'b0;
    check("done_seen", done_seen, 1);
    if (done_seen) begin
      check("error_at_done", err_d, exp_err);
      check("busy_at_done", busy_d, 0);
      check("trailing_ones_out", t1_d, t1);
      check("bits_consumed", rd, exp_pos);
      if (!stall && exp_err == 0) check("done_latency", done_cyc, t1 + 2 * (tc - t1) + 2);
    end
    check("strobe_count", got_kind.size(), exp_kind.size());
    n = (got_kind.size() < exp_kind.size()) ? got_kind.size() : exp_kind.size();
    for (int i = 0; i < n; i++) begin
      check("strobe_kind", got_kind[i], exp_kind[i]);
      check("code_num", got_code[i], exp_code[i]);
      if (exp_kind[i] == 2) check("suffix_length", got_sl[i], exp_sl[i]);
    end
    @(negedge Clk);
    check("done_width", Done, 0);
  endtask

  initial begin
    int tc, t1;
    nReset = 1'b0; Start = 1'b0; TotalCoeffIn = 5'd0; TrailingOnesIn = 2'd0;
    BitsIn = 16'd0; BitsValid = 1'b0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check("reset_outputs", {ShiftEn, ShiftAmt, TrailingOneMode, LPUTrig, CodeNum, SuffixLength,
                            TrailingOnes, Busy, Done, Error}, 0);
    nReset = 1'b1;

    // Two trailing-one signs 1 then 0
    stream.delete(); push_bits(2'b10, 2); push_ones(8);
    run_block(2, 2, 1'b0, 1'b0);
    check("t1_sign0", got_code.size() > 0 ? got_code[0] : -1, 1);
    check("t1_sign1", got_code.size() > 1 ? got_code[1] : -1, 0);
    check("t1_consumed", rd, 2);

    // Three levels: "1" / "1"+"0" / "01"+"1"
    stream.delete(); push_bits(6'b110011, 6); push_ones(8);
    run_block(3, 0, 1'b0, 1'b0);
    check("l3_code0", got_code.size() > 0 ? got_code[0] : -1, 0);
    check("l3_sl1", got_sl.size() > 1 ? got_sl[1] : -1, 1);
    check("l3_code2", got_code.size() > 2 ? got_code[2] : -1, 3);

    // Prefix 14 escape with 4-bit suffix
    stream.delete(); push_bits(32'd0, 14); push_bits(5'b10101, 5); push_ones(4);
    run_block(1, 0, 1'b0, 1'b0);
    check("esc14_code", got_code.size() > 0 ? got_code[0] : -1, 19);
    check("esc14_consumed", rd, 19);

    // Prefix 15 escape with 12-bit suffix
    stream.delete(); push_bits(32'd0, 15); push_bits(13'b1_0000_0000_0001, 13); push_ones(4);
    run_block(1, 0, 1'b0, 1'b0);
    check("esc15_code", got_code.size() > 0 ? got_code[0] : -1, 31);

    // Large TotalCoeff starts at suffixLength 1, then a big level bumps it
    stream.delete(); push_bits(4'b0010, 4); push_ones(40);
    run_block(11, 0, 1'b0, 1'b0);
    check("tc11_sl0", got_sl.size() > 0 ? got_sl[0] : -1, 1);
    check("tc11_sl1", got_sl.size() > 1 ? got_sl[1] : -1, 2);

    // All-zero window in PREFIX
    stream.delete();
    run_block(1, 0, 1'b0, 1'b0);
    check("err_no_lpu", got_kind.size(), 0);
    check("err_sticky", Error, 1);

    // Empty block
    stream.delete(); push_ones(4);
    run_block(0, 0, 1'b0, 1'b0);

    // Reset asserted while in SUFFIX
    @(posedge Clk); #1;
    TotalCoeffIn = 5'd11; TrailingOnesIn = 2'd1; BitsIn = 16'hFFFF; BitsValid = 1'b1; Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    @(posedge Clk); #1;
    check("rst_pre_t1mode", TrailingOneMode, 1);
    check("rst_pre_code", CodeNum, 1);
    @(posedge Clk); #1;
    check("rst_pre_shift", ShiftEn, 1);
    nReset = 1'b0;
    #1;
    check("rst_mid_outputs", {ShiftEn, ShiftAmt, TrailingOneMode, LPUTrig, CodeNum, SuffixLength,
                              TrailingOnes, Busy, Done, Error}, 0);
    repeat (2) begin
      @(negedge Clk);
      check("rst_hold_outputs", {ShiftEn, ShiftAmt, TrailingOneMode, LPUTrig, CodeNum, SuffixLength,
                                 TrailingOnes, Busy, Done, Error}, 0);
    end
    nReset = 1'b1;
    BitsValid = 1'b0;

    // Random blocks, alternating stalls and ignored mid-block Start pulses
    for (int n = 0; n < 40; n++) begin
      tc = $urandom_range(0, 16);
      t1 = $urandom_range(0, (tc < 3) ? tc : 3);
      stream.delete();
      for (int b = 0; b < 400; b++) stream.push_back(1'($urandom_range(0, 1)));
      run_block(tc, t1, 1'(n % 2), (n % 3) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/level_code_decoder.md
# level_code_decoder

Upstream stage of the CAVLC level path. Per residual block it parses trailing-one sign bits, `level_prefix` and `level_suffix` from an MSB-first bitstream window. It computes `levelCode` and maintains the adaptive `suffixLength` (H.264 9.2.2). Each result is presented as `CodeNum` / `SuffixLength` with a one-cycle `TrailingOneMode` or `LPUTrig` strobe to the level processing unit.

## Interface
- `MAX_SUFFIX_LEN`, 6, saturation value of `suffixLength`
- `Clk`  in  1  clock
- `nReset`  in  1  reset, asynchronous, active-low
- `Start`  in  1  one-cycle pulse; latches `TotalCoeffIn` and `TrailingOnesIn`
- `TotalCoeffIn`  in  5  coefficient count, 0..16
- `TrailingOnesIn`  in  2  trailing-one count, 0..3
- `BitsIn`  in  16  bitstream window; `BitsIn[15]` is the next bit
- `BitsValid`  in  1  `BitsIn` is valid this cycle
- `ShiftEn`  out  1  consume `ShiftAmt` bits this cycle
- `ShiftAmt`  out  5  bits consumed, 1..16
- `TrailingOneMode`  out  1  strobe; trailing-one sign is in `CodeNum[0]`
- `LPUTrig`  out  1  strobe; `CodeNum` holds `levelCode`
- `CodeNum`  out  14  sign bit or `levelCode`
- `SuffixLength`  out  3  `suffixLength` used to decode this level
- `TrailingOnes`  out  2  latched `TrailingOnesIn`
- `Busy`  out  1  high from `Start` until `Done`
- `Done`  out  1  one-cycle pulse after the last level
- `Error`  out  1  sticky until next `Start`; set on `level_prefix` > 15

## Operation
- FSM states: IDLE, T1SIGN, PREFIX, SUFFIX, FINISH.
- IDLE, on `Start`:
  - Latch inputs, clear `Error`, set index i=0.
  - Initial `suffixLength` = 1 if `TotalCoeffIn` > 10 and `TrailingOnesIn` < 3, else 0.
  - Next state: T1SIGN if `TrailingOnesIn` > 0, PREFIX if `TotalCoeffIn` > `TrailingOnesIn`, FINISH otherwise.
- T1SIGN (one sign per cycle, only while `BitsValid`):
  - `ShiftEn`=1, `ShiftAmt`=1.
  - `CodeNum` = {13'b0, `BitsIn[15]`}, `TrailingOneMode` pulse, i++.
  - After `TrailingOnes` signs: PREFIX or FINISH.
- PREFIX (only while `BitsValid`):
  - p = leading zeros of `BitsIn`.
  - If `BitsIn`=0 (p ≥ 16): set `Error`, go to FINISH, no shift.
  - Otherwise shift p+1, latch p, go to SUFFIX.
- SUFFIX:
  - Suffix size s = 4 if p=14 and sl=0; s = 12 if p=15; s = sl otherwise.
  - If s>0, wait for `BitsValid`, then shift s. If s=0, proceed without waiting and without `ShiftEn`.
  - `levelCode` = (p<<sl) + `BitsIn[15 -: s]`, plus 15 if p=15 and sl=0.
  - `CodeNum` = `levelCode` without the first-coefficient +2; the downstream stage applies that adjustment.
  - `SuffixLength` = sl before update. `LPUTrig` pulse, i++.
- suffixLength update, after each SUFFIX:
  - adj = `levelCode` + 2 if this is the first non-T1 level and `TrailingOnes` < 3, else `levelCode`.
  - |level| = (adj+2)>>1.
  - If sl=0: sl=1. Then if |level| > (3<<(sl-1)) and sl < `MAX_SUFFIX_LEN`: sl++.
  - Next state: PREFIX if i < TotalCoeff, FINISH otherwise.
- FINISH: `Done` pulse for one cycle, return to IDLE.
- `Start` outside IDLE is ignored.
- `TotalCoeffIn`=0: IDLE → FINISH → IDLE, no strobes.
- Arithmetic: 14-bit unsigned; max `levelCode` is 15<<6 + 4095 = 5055, so no overflow.

## Timing
- Reset values: all outputs 0, state IDLE, sl=0.
- Reset asserted mid-block aborts immediately: no `Done`, no further strobes.
- `ShiftEn` is combinational from state and `BitsIn`. The upstream shifter updates `BitsIn` for the next cycle.
- `CodeNum`, `SuffixLength`, `TrailingOneMode`, `LPUTrig` and `Done` are registered: valid the cycle after the consuming cycle, strobes one cycle wide.
- Throughput with `BitsValid` held high: 1 cycle per trailing one, 2 cycles per non-T1 level.
- `BitsValid` low stalls T1SIGN, PREFIX, and SUFFIX with s>0. No strobe is issued during a stall.

## Structure
- `cavlc_pkg` holds:
  - the state enum;
  - `MAX_SUFFIX_LEN`;
  - the escape constants: prefix 14 → size 4, prefix 15 → size 12, offset 15;
  - widths for `CodeNum` (14) and `LevelOut` (13), shared with the downstream stage.
- Sub-module `leading_zero_counter`: 16-bit input; 5-bit count output (16 when the input is all zeros); purely combinational.

## Test plan
- TC=2, T1=2, bits `10…` → two `TrailingOneMode` strobes with `CodeNum`=1 then 0. Shifts of 1 and 1, then `Done`.
- TC=3, T1=0, bits `1` `1` `01`:
  - level 1: `CodeNum`=0, `SuffixLength`=0;
  - level 2: p=0, shift 1, suffix bit 0 → `CodeNum`=0, `SuffixLength`=1;
  - level 3: consumes `01` from the next prefix.
  - Check `Done` after the third `LPUTrig`.
- TC=1, T1=0, sl=0, 14 zeros + `1` + `0101` → shifts 15 then 4, `CodeNum`=19.
- TC=1, sl=0, 15 zeros + `1` + 12'h001 → `CodeNum`=31.
- TC=11, T1=0 → first `LPUTrig` has `SuffixLength`=1. A level with |level|>3 bumps the next `SuffixLength` to 2.
- 16 zero bits in PREFIX → `Error`=1, `Done` pulse, no `LPUTrig`. Separately, `nReset` low in SUFFIX → all outputs 0 next cycle.
